// File: rtl/tetris_input_pkg.sv
// Shared types and default tuning for the player-input front end.
// Latency: n/a (types, constants and a pure next-state helper).
// Backpressure: n/a.
package tetris_input_pkg;

   typedef enum logic [1:0] {
      CENTER = 2'd0,
      LEFT   = 2'd1,
      RIGHT  = 2'd2
   } axis_state_t;

   // Defaults shared with tetris_top (50 MHz system clock)
   localparam int unsigned DEF_ADC_W         = 12;
   localparam int unsigned DEF_NUM_BTN       = 3;
   localparam int unsigned DEF_DEBOUNCE_CYC  = 500_000;
   localparam int unsigned DEF_LO_ON         = 1121;
   localparam int unsigned DEF_LO_OFF        = 1250;
   localparam int unsigned DEF_HI_OFF        = 2050;
   localparam int unsigned DEF_HI_ON         = 2179;
   localparam int unsigned DEF_DAS_DELAY_CYC = 8_000_000;
   localparam int unsigned DEF_DAS_RPT_CYC   = 2_500_000;

   // Hysteretic axis decision; all compares are unsigned on a zero-extended sample.
   // A direct LEFT<->RIGHT swing is checked before the return-to-centre band.
   function automatic axis_state_t axis_next(
      input axis_state_t cur,
      input logic [31:0] adc,
      input logic [31:0] lo_on,
      input logic [31:0] lo_off,
      input logic [31:0] hi_off,
      input logic [31:0] hi_on
   );
      axis_state_t nxt;
      nxt = cur;
      case (cur)
         CENTER: begin
            if (adc < lo_on)       nxt = LEFT;
            else if (adc > hi_on)  nxt = RIGHT;
         end
         LEFT: begin
            if (adc > hi_on)       nxt = RIGHT;
            else if (adc >= lo_off) nxt = CENTER;
         end
         RIGHT: begin
            if (adc < lo_on)       nxt = LEFT;
            else if (adc <= hi_off) nxt = CENTER;
         end
         default: nxt = CENTER;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/input_debounce.sv
// One pushbutton: 2-FF synchroniser, stability counter, registered press pulse.
// Latency: raw edge -> o_level/o_press = 2 + DEBOUNCE_CYC + 1 cycles.
// Backpressure: none; free-running, press is a 1-cycle strobe.
module input_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 500_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn_n,
   output logic o_level,
   output logic o_press
);

   localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_state;    // debounced, 1 = pressed
   logic            r_level;    // registered copy driving the output
   logic            r_press;
   logic [DB_W-1:0] r_cnt;

   // Synchronise, count consecutive disagreeing samples, flip after DEBOUNCE_CYC of them
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         r_level <= r_state;
         // Rising debounced state only; release is silent
         r_press <= r_state & ~r_level;
         if (r_sync2 == ~r_state) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_LAST) begin
            r_state <= ~r_state;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + DB_W'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Player-input front end: debounced buttons plus joystick axis -> discrete move pulses with auto-repeat.
// Latency: adc_valid -> first move pulse 1 cycle; buttons 2 + DEBOUNCE_CYC + 1 cycles.
// Backpressure: none; outputs are 1-cycle strobes, enable=0 squashes moves and centres the axis.
module tetris_input_ctrl
   import tetris_input_pkg::*;
#(
   parameter int unsigned ADC_W         = DEF_ADC_W,
   parameter int unsigned NUM_BTN       = DEF_NUM_BTN,
   parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
   parameter int unsigned LO_ON         = DEF_LO_ON,
   parameter int unsigned LO_OFF        = DEF_LO_OFF,
   parameter int unsigned HI_OFF        = DEF_HI_OFF,
   parameter int unsigned HI_ON         = DEF_HI_ON,
   parameter int unsigned DAS_DELAY_CYC = DEF_DAS_DELAY_CYC,
   parameter int unsigned DAS_RPT_CYC   = DEF_DAS_RPT_CYC
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [ADC_W-1:0]   i_adc_value,
   input  logic               i_adc_valid,
   input  logic [NUM_BTN-1:0] i_btn_n,
   output logic [NUM_BTN-1:0] o_btn_level,
   output logic [NUM_BTN-1:0] o_btn_press,
   output logic               o_move_left,
   output logic               o_move_right,
   output logic               o_dir_active
);

   localparam int unsigned      DAS_MAX    = (DAS_DELAY_CYC > DAS_RPT_CYC) ? DAS_DELAY_CYC : DAS_RPT_CYC;
   localparam int unsigned      DAS_W      = $clog2(DAS_MAX + 1);
   localparam logic [DAS_W-1:0] DAS_LOAD   = DAS_W'(DAS_DELAY_CYC - 1);
   localparam logic [DAS_W-1:0] DAS_RELOAD = DAS_W'(DAS_RPT_CYC - 1);

   // Parameter sanity: threshold ordering and non-zero timings
   if (!((LO_ON < LO_OFF) && (LO_OFF <= HI_OFF) && (HI_OFF < HI_ON))) begin : g_bad_thresholds
      $error("tetris_input_ctrl: need LO_ON < LO_OFF <= HI_OFF < HI_ON");
   end
   if ((DEBOUNCE_CYC < 1) || (DAS_DELAY_CYC < 1) || (DAS_RPT_CYC < 1)) begin : g_bad_timing
      $error("tetris_input_ctrl: DEBOUNCE_CYC, DAS_DELAY_CYC, DAS_RPT_CYC must be >= 1");
   end
   if ((ADC_W < 1) || (ADC_W > 32)) begin : g_bad_adc_w
      $error("tetris_input_ctrl: ADC_W must be 1..32");
   end

   // One debouncer per button; not gated by enable so pause still works while paused
   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      input_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_btn_n (i_btn_n[g]),
         .o_level (o_btn_level[g]),
         .o_press (o_btn_press[g])
      );
   end

   axis_state_t      r_state;
   logic [DAS_W-1:0] r_das_cnt;
   logic             r_move_left;
   logic             r_move_right;
   logic             r_dir_active;
   axis_state_t      w_next;
   logic [31:0]      w_adc_ext;

   assign w_adc_ext = 32'(i_adc_value);

   // Axis only re-evaluates on a fresh ADC sample
   always_comb begin
      w_next = r_state;
      if (i_adc_valid) begin
         w_next = axis_next(r_state, w_adc_ext, LO_ON, LO_OFF, HI_OFF, HI_ON);
      end
   end

   // Axis FSM with DAS: pulse on entry, first repeat after DAS_DELAY_CYC, then every DAS_RPT_CYC
   always_ff @(posedge i_clk) begin
      if (i_reset || !i_enable) begin
         r_state      <= CENTER;
         r_das_cnt    <= '0;
         r_move_left  <= 1'b0;
         r_move_right <= 1'b0;
         r_dir_active <= 1'b0;
      end else begin
         r_move_left  <= 1'b0;
         r_move_right <= 1'b0;
         r_state      <= w_next;
         r_dir_active <= (w_next != CENTER);
         if (w_next == CENTER) begin
            r_das_cnt <= '0;
         end else if (w_next != r_state) begin
            // New direction (from centre or a direct swing): fire it alone and restart DAS
            r_das_cnt    <= DAS_LOAD;
            r_move_left  <= (w_next == LEFT);
            r_move_right <= (w_next == RIGHT);
         end else if (r_das_cnt == '0) begin
            r_das_cnt    <= DAS_RELOAD;
            r_move_left  <= (r_state == LEFT);
            r_move_right <= (r_state == RIGHT);
         end else begin
            r_das_cnt <= r_das_cnt - DAS_W'(1);
         end
      end
   end

   assign o_move_left  = r_move_left;
   assign o_move_right = r_move_right;
   assign o_dir_active = r_dir_active;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: directed stimulus, expected pulses queued with absolute cycle stamps.
// A negedge monitor pops and compares every pulse the DUT emits; levels are checked inline.
// Short timing overrides keep the run to a few hundred cycles.
module tb_tetris_input_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [11:0] adc;
   logic        valid;
   logic [2:0]  btn_n;
   logic [2:0]  btn_level;
   logic [2:0]  btn_press;
   logic        move_left;
   logic        move_right;
   logic        dir_active;

   typedef struct {
      int cyc;
      int kind;   // 0..2 = btn_press bit, 3 = move_left, 4 = move_right
   } ev_t;

   ev_t exp_q[$];
   int  cyc    = 0;
   int  errs   = 0;
   int  checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   tetris_input_ctrl #(
      .ADC_W         (12),
      .NUM_BTN       (3),
      .DEBOUNCE_CYC  (4),
      .LO_ON         (1121),
      .LO_OFF        (1250),
      .HI_OFF        (2050),
      .HI_ON         (2179),
      .DAS_DELAY_CYC (10),
      .DAS_RPT_CYC   (3)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_enable     (enable),
      .i_adc_value  (adc),
      .i_adc_valid  (valid),
      .i_btn_n      (btn_n),
      .o_btn_level  (btn_level),
      .o_btn_press  (btn_press),
      .o_move_left  (move_left),
      .o_move_right (move_right),
      .o_dir_active (dir_active)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_ev(input int c, input int k);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic adc_send(input int v);
      adc   = 12'(v);
      valid = 1'b1;
      step(1);
      valid = 1'b0;
   endtask

   // Monitor: every emitted pulse must match the head of the expected queue
   always @(negedge clk) begin
      logic [4:0] pulses;
      pulses = {move_right, move_left, btn_press};
      if (move_left === 1'b1 && move_right === 1'b1) begin
         checks++;
         errs++;
         $display("FAIL both_moves: left and right high together (cycle %0d)", cyc);
      end
      for (int k = 0; k < 5; k++) begin
         if (pulses[k] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errs++;
               $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required none", k, cyc);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.kind != k) begin
                  errs++;
                  $display("FAIL pulse_order: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                           k, cyc, e.kind, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      int t;
      int t2;
      int das_l[9] = '{1, 11, 14, 17, 20, 23, 26, 29, 32};

      reset  = 1'b1;
      enable = 1'b1;
      btn_n  = 3'b111;
      adc    = 12'd2000;
      valid  = 1'b0;

      // Reset state
      step(3);
      chk("rst_btn_level", 32'(btn_level), 0);
      chk("rst_btn_press", 32'(btn_press), 0);
      chk("rst_move_left", 32'(move_left), 0);
      chk("rst_move_right", 32'(move_right), 0);
      chk("rst_dir_active", 32'(dir_active), 0);
      reset = 1'b0;
      step(1);
      chk("post_rst_outs", 32'({btn_level, btn_press, move_left, move_right, dir_active}), 0);

      // Button 0 held: press pulse and level at +7, level drops at release +7
      t = cyc;
      btn_n[0] = 1'b0;
      expect_ev(t + 7, 0);
      step(6);
      chk("b0_level_pre", 32'(btn_level[0]), 0);
      step(1);
      chk("b0_level_on", 32'(btn_level[0]), 1);
      step(10);
      btn_n[0] = 1'b1;
      step(6);
      chk("b0_level_hold", 32'(btn_level[0]), 1);
      step(1);
      chk("b0_level_off", 32'(btn_level[0]), 0);

      // Button 1 glitch of 3 cycles: ignored
      btn_n[1] = 1'b0;
      step(3);
      btn_n[1] = 1'b1;
      step(10);
      chk("b1_glitch_level", 32'(btn_level[1]), 0);

      // Button 2 low for exactly DEBOUNCE_CYC cycles: accepted
      t = cyc;
      btn_n[2] = 1'b0;
      expect_ev(t + 7, 2);
      step(4);
      btn_n[2] = 1'b1;
      step(3);
      chk("b2_min_level_on", 32'(btn_level[2]), 1);
      step(4);
      chk("b2_min_level_off", 32'(btn_level[2]), 0);
      step(3);

      // Left with DAS: +1, +11, then every 3
      t = cyc;
      foreach (das_l[i]) expect_ev(t + das_l[i], 3);
      adc_send(1000);
      step(29);
      chk("left_dir_active", 32'(dir_active), 1);
      // Hysteresis: 1200 keeps LEFT and the repeat at +32, 1260 returns to CENTER
      adc_send(1200);
      step(1);
      chk("hyst_1200_left", 32'(dir_active), 1);
      adc_send(1260);
      chk("hyst_1260_center", 32'(dir_active), 0);
      step(5);

      // Direct swing LEFT -> RIGHT: single right pulse, DAS restarts
      t = cyc;
      expect_ev(t + 1, 3);
      adc_send(1000);
      step(4);
      t2 = cyc;
      expect_ev(t2 + 1, 4);
      expect_ev(t2 + 11, 4);
      adc_send(3000);
      step(11);
      chk("swing_right_active", 32'(dir_active), 1);
      adc_send(1500);
      chk("swing_back_center", 32'(dir_active), 0);
      step(3);

      // Enable low forces CENTER; next sample re-enters LEFT with an immediate pulse
      t = cyc;
      expect_ev(t + 1, 3);
      adc_send(1000);
      step(2);
      enable = 1'b0;
      step(1);
      chk("disable_dir", 32'(dir_active), 0);
      step(4);
      enable = 1'b1;
      step(3);
      chk("reenable_center", 32'(dir_active), 0);
      t = cyc;
      expect_ev(t + 1, 3);
      expect_ev(t + 11, 3);
      adc_send(1000);
      chk("reenable_left", 32'(dir_active), 1);

      // Reset mid-repeat: cancels the repeat due at +14, axis back to CENTER
      step(12);
      reset = 1'b1;
      step(1);
      chk("mid_rst_outs", 32'({btn_level, btn_press, move_left, move_right, dir_active}), 0);
      step(2);
      reset = 1'b0;
      step(1);
      chk("mid_rst_release", 32'({btn_level, btn_press, move_left, move_right, dir_active}), 0);
      t = cyc;
      expect_ev(t + 1, 3);
      adc_send(1000);
      chk("post_rst_entry", 32'(dir_active), 1);
      step(3);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(3);

      chk("leftover_expected", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
